// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: conditions hps_io keyboard/joystick inputs into two
// registered player control words for Main. Keyboard events are decoded into
// held-key state and ORed with the joysticks. Coin is stretched to a fixed
// pulse, and pause is optionally a toggle latch.
// Optional macro INPUT_SOCD_EN: cancels opposing directions (up+down,
// left+right) per player before the output register.

// Per-player stage: output register, coin pulse stretcher, pause latch.
module arcade_input_player #(
  parameter int unsigned COIN_CYCLES  = 1000000,
  parameter bit          PAUSE_TOGGLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] raw_i,
  output logic [10:0] ctrl_o
);
  localparam int CW = $clog2(COIN_CYCLES + 1);

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_st_e;

  coin_st_e        st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [8:0]      dir_q;
  logic            coin_prev_q, pause_prev_q, pause_q, pause_d;

  // Registered state: direction/button bits, coin FSM, edge history, pause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q        <= '0;
      st_q         <= C_IDLE;
      cnt_q        <= '0;
      coin_prev_q  <= 1'b0;
      pause_prev_q <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      dir_q        <= raw_i[8:0];
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      coin_prev_q  <= raw_i[9];
      pause_prev_q <= raw_i[10];
      pause_q      <= pause_d;
    end
  end

  // Coin FSM: one fixed-length pulse per press; a held coin must be released
  // before another pulse can start, and an early release never shortens it.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      C_IDLE: begin
        if (raw_i[9] && !coin_prev_q) begin
          st_d  = C_PULSE;
          cnt_d = CW'(COIN_CYCLES);
        end
      end
      C_PULSE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) st_d = raw_i[9] ? C_WAIT : C_IDLE;
      end
      C_WAIT: begin
        if (!raw_i[9]) st_d = C_IDLE;
      end
      default: begin
        st_d  = C_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // Pause: either flip on each rising edge, or just follow the raw input.
  always_comb begin
    if (PAUSE_TOGGLE) pause_d = pause_q ^ (raw_i[10] & ~pause_prev_q);
    else              pause_d = raw_i[10];
  end

  assign ctrl_o = {pause_q, st_q == C_PULSE, dir_q};
endmodule

module arcade_input_ctrl #(
  parameter int unsigned COIN_CYCLES  = 1000000,
  parameter bit          PAUSE_TOGGLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] ps2_key,
  input  logic [31:0] joystick_0,
  input  logic [31:0] joystick_1,
  input  logic        osd_open,
  output logic [10:0] p1_ctrl,
  output logic [10:0] p2_ctrl
);
  logic [1:0][10:0] keys_q, keys_d, hit, joy, ctrl;
  logic             toggle_q, primed_q, evt;
  logic             unused_bits;

  // Upper joystick bits and the extended flag carry no meaning here.
  assign unused_bits = ^{joystick_0[31:11], joystick_1[31:11], ps2_key[8]};

  assign joy = {joystick_1[10:0], joystick_0[10:0]};
  assign evt = primed_q && (ps2_key[10] != toggle_q);

  // Scan code to (player, bit). Extended prefix is ignored, so right ctrl/alt
  // land on the same bits as the left-hand keys.
  always_comb begin
    hit = '0;
    case (ps2_key[7:0])
      8'h74: hit[0][0]  = 1'b1;
      8'h6B: hit[0][1]  = 1'b1;
      8'h72: hit[0][2]  = 1'b1;
      8'h75: hit[0][3]  = 1'b1;
      8'h14: hit[0][4]  = 1'b1;
      8'h11: hit[0][5]  = 1'b1;
      8'h29: hit[0][6]  = 1'b1;
      8'h12: hit[0][7]  = 1'b1;
      8'h16: hit[0][8]  = 1'b1;
      8'h2E: hit[0][9]  = 1'b1;
      8'h4D: hit[0][10] = 1'b1;
      8'h34: hit[1][0]  = 1'b1;
      8'h23: hit[1][1]  = 1'b1;
      8'h2B: hit[1][2]  = 1'b1;
      8'h2D: hit[1][3]  = 1'b1;
      8'h1C: hit[1][4]  = 1'b1;
      8'h1B: hit[1][5]  = 1'b1;
      8'h15: hit[1][6]  = 1'b1;
      8'h1D: hit[1][7]  = 1'b1;
      8'h1E: hit[1][8]  = 1'b1;
      8'h36: hit[1][9]  = 1'b1;
      default: hit = '0;
    endcase
  end

  // Held-key update: OSD focus wipes everything and masks events.
  always_comb begin
    keys_d = keys_q;
    if (osd_open) begin
      keys_d = '0;
    end else if (evt) begin
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 11; b++)
          if (hit[p][b]) keys_d[p][b] = ps2_key[9];
    end
  end

  // Event-bus tracking; primed keeps a stale toggle level at release silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q   <= '0;
      toggle_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      keys_q   <= keys_d;
      toggle_q <= ps2_key[10];
      primed_q <= 1'b1;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pl
    logic [10:0] raw;

    // Merge keyboard and joystick, optionally cancelling opposing directions.
    always_comb begin
      raw = keys_q[p] | joy[p];
`ifdef INPUT_SOCD_EN
      if (raw[3] && raw[2]) raw[3:2] = 2'b00;
      if (raw[1] && raw[0]) raw[1:0] = 2'b00;
`endif
    end

    arcade_input_player #(
      .COIN_CYCLES  (COIN_CYCLES),
      .PAUSE_TOGGLE (PAUSE_TOGGLE)
    ) u_player (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw),
      .ctrl_o (ctrl[p])
    );
  end

  assign p1_ctrl = ctrl[0];
  assign p2_ctrl = ctrl[1];
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl (COIN_CYCLES=8, PAUSE_TOGGLE=1): directed
// scenarios followed by random traffic, all compared each cycle against a
// behavioural model of held keys, coin pulse timing and the pause latch.
module tb_arcade_input_ctrl;
  localparam int unsigned NC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ps2_key;
  logic [31:0] joystick_0, joystick_1;
  logic        osd_open;
  logic [10:0] p1_ctrl, p2_ctrl;

  always #5 clk = ~clk;

  arcade_input_ctrl #(.COIN_CYCLES(NC), .PAUSE_TOGGLE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .osd_open   (osd_open),
    .p1_ctrl    (p1_ctrl),
    .p2_ctrl    (p2_ctrl)
  );

  int total = 0;
  int bad   = 0;

  // Scan code for each output bit, per player.
  byte unsigned p1codes [11] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11,
                                 8'h29, 8'h12, 8'h16, 8'h2E, 8'h4D};
  byte unsigned p2codes [10] = '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B,
                                 8'h15, 8'h1D, 8'h1E, 8'h36};

  // Reference state
  bit          keyheld [256];
  bit          m_primed, m_tog;
  int          pulse_left [2];
  bit          need_rel [2], cprev [2], pprev [2], latch [2];
  logic [10:0] exp_ctrl [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] raw_of(input int p);
    logic [10:0] v;
    v = (p == 0) ? joystick_0[10:0] : joystick_1[10:0];
    for (int b = 0; b < 11; b++) begin
      if (p == 0) v[b] = v[b] | keyheld[p1codes[b]];
      else if (b < 10) v[b] = v[b] | keyheld[p2codes[b]];
    end
`ifdef INPUT_SOCD_EN
    if (v[3] && v[2]) v[3:2] = 2'b00;
    if (v[1] && v[0]) v[1:0] = 2'b00;
`endif
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    logic [10:0] r [2];
    if (rst) begin
      foreach (keyheld[i]) keyheld[i] = 1'b0;
      m_primed = 1'b0;
      m_tog    = 1'b0;
      for (int p = 0; p < 2; p++) begin
        pulse_left[p] = 0; need_rel[p] = 0; cprev[p] = 0; pprev[p] = 0;
        latch[p] = 0; exp_ctrl[p] = '0;
      end
      return;
    end
    r[0] = raw_of(0);
    r[1] = raw_of(1);
    for (int p = 0; p < 2; p++) begin
      exp_ctrl[p][8:0] = r[p][8:0];
      if (pulse_left[p] > 0) begin
        pulse_left[p]--;
        if (pulse_left[p] == 0 && r[p][9]) need_rel[p] = 1'b1;
      end else if (need_rel[p]) begin
        if (!r[p][9]) need_rel[p] = 1'b0;
      end else if (r[p][9] && !cprev[p]) begin
        pulse_left[p] = NC;
      end
      cprev[p] = r[p][9];
      exp_ctrl[p][9] = (pulse_left[p] > 0);
      if (r[p][10] && !pprev[p]) latch[p] = ~latch[p];
      pprev[p] = r[p][10];
      exp_ctrl[p][10] = latch[p];
    end
    if (osd_open) begin
      foreach (keyheld[i]) keyheld[i] = 1'b0;
    end else if (m_primed && ps2_key[10] != m_tog) begin
      keyheld[ps2_key[7:0]] = ps2_key[9];
    end
    m_tog    = ps2_key[10];
    m_primed = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("p1_model", 32'(p1_ctrl), 32'(exp_ctrl[0]));
    chk("p2_model", 32'(p2_ctrl), 32'(exp_ctrl[1]));
  endtask

  task automatic key_evt(input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  initial begin
    int hi, rises;
    logic prevb;
    byte unsigned pool [21];
    for (int i = 0; i < 11; i++) pool[i] = p1codes[i];
    for (int i = 0; i < 10; i++) pool[11 + i] = p2codes[i];

    rst = 1'b1; ps2_key = 11'h400; joystick_0 = '0; joystick_1 = '0; osd_open = 1'b0;
    repeat (3) step();
    chk("rst_p1", 32'(p1_ctrl), 32'd0);
    chk("rst_p2", 32'(p2_ctrl), 32'd0);
    rst = 1'b0;

    // Stale toggle level at release must not decode anything.
    ps2_key[7:0] = 8'h75; ps2_key[9] = 1'b1;
    repeat (100) step();
    chk("stale_tog", 32'(p1_ctrl), 32'd0);

    // Key 75 press/release timing and OR with joystick.
    key_evt(1'b1, 8'h75);
    step(); chk("up_lat1", 32'(p1_ctrl[3]), 32'd0);
    step(); chk("up_press", 32'(p1_ctrl[3]), 32'd1);
    key_evt(1'b0, 8'h75);
    step(); chk("up_hold", 32'(p1_ctrl[3]), 32'd1);
    step(); chk("up_rel", 32'(p1_ctrl[3]), 32'd0);
    key_evt(1'b1, 8'h75); joystick_0[3] = 1'b1;
    step(); step();
    key_evt(1'b0, 8'h75);
    repeat (3) step();
    chk("up_joy_or", 32'(p1_ctrl[3]), 32'd1);
    joystick_0 = '0;
    step(); chk("up_clear", 32'(p1_ctrl[3]), 32'd0);

    // Coin held for 50 cycles: one 8-cycle pulse.
    joystick_1[9] = 1'b1; hi = 0; rises = 0; prevb = 1'b0;
    repeat (50) begin
      step();
      if (p2_ctrl[9]) hi++;
      if (p2_ctrl[9] && !prevb) rises++;
      prevb = p2_ctrl[9];
    end
    chk("coin_len", 32'(hi), 32'd8);
    chk("coin_once", 32'(rises), 32'd1);
    joystick_1[9] = 1'b0; repeat (5) step();
    joystick_1[9] = 1'b1; hi = 0;
    repeat (20) begin step(); if (p2_ctrl[9]) hi++; end
    chk("coin_len2", 32'(hi), 32'd8);
    joystick_1[9] = 1'b0; repeat (5) step();
    joystick_1[9] = 1'b1; hi = 0;
    repeat (2) begin step(); if (p2_ctrl[9]) hi++; end
    joystick_1[9] = 1'b0;
    repeat (20) begin step(); if (p2_ctrl[9]) hi++; end
    chk("coin_tap", 32'(hi), 32'd8);

    // Pause toggle via key 4D.
    key_evt(1'b1, 8'h4D); step(); key_evt(1'b0, 8'h4D); repeat (3) step();
    chk("pause_on", 32'(p1_ctrl[10]), 32'd1);
    key_evt(1'b1, 8'h4D); step(); key_evt(1'b0, 8'h4D); repeat (3) step();
    chk("pause_off", 32'(p1_ctrl[10]), 32'd0);

    // OSD clear beats a coincident event; joystick passes through.
    key_evt(1'b1, 8'h14); repeat (3) step();
    chk("b1_held", 32'(p1_ctrl[4]), 32'd1);
    key_evt(1'b1, 8'h16); osd_open = 1'b1; joystick_0[5] = 1'b1;
    step(); osd_open = 1'b0; step(); step();
    chk("osd_b1", 32'(p1_ctrl[4]), 32'd0);
    chk("osd_start", 32'(p1_ctrl[8]), 32'd0);
    chk("osd_joy", 32'(p1_ctrl[5]), 32'd1);
    joystick_0 = '0; step();

    // Opposing directions.
    joystick_0[3:0] = 4'b1111; step();
`ifdef INPUT_SOCD_EN
    chk("socd_lr", 32'(p1_ctrl[1:0]), 32'd0);
    chk("socd_ud", 32'(p1_ctrl[3:2]), 32'd0);
`else
    chk("socd_lr", 32'(p1_ctrl[1:0]), 32'd3);
    chk("socd_ud", 32'(p1_ctrl[3:2]), 32'd3);
`endif
    joystick_0 = '0; step();

    // Random traffic, with one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ps2_key[10] = ~ps2_key[10];
        ps2_key[9]  = 1'($urandom);
        ps2_key[8]  = 1'($urandom);
        ps2_key[7:0] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 20)];
      end else begin
        ps2_key[9:0] = 10'($urandom);
      end
      if ($urandom_range(0, 7) == 0) joystick_0[$urandom_range(0, 10)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) joystick_1[$urandom_range(0, 10)] ^= 1'b1;
      joystick_0[31:11] = 21'($urandom);
      joystick_1[31:11] = 21'($urandom);
      osd_open = ($urandom_range(0, 31) == 0);
      if (i == 1500) begin
        rst = 1'b1; step(); step();
        chk("rst_mid", 32'({p1_ctrl, p2_ctrl}), 32'd0);
        rst = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/arcade_input_ctrl.md
Name: arcade_input_ctrl

Overview:
- Input conditioning stage between hps_io and the Main core's joystick ports, running on clk_sys.
- Decodes the hps_io ps2_key event bus into held-key state.
- ORs keyboard state with the joystick_0/joystick_1 words into two registered player control words.
- Stretches coin pulses to a fixed length and optionally latches pause as a toggle, so Main sees clean, timed inputs.

Parameters:
- COIN_CYCLES, 1000000: length of the coin output pulse, in clk cycles; range 1..2^24-1.
- PAUSE_TOGGLE, 1: 1 = each pause press toggles a pause latch; 0 = pause output follows the raw pause input.

Ports:
- clk  in  1  system clock (clk_sys)
- rst  in  1  asynchronous, active-high reset
- ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [8] extended, [7:0] scan code
- joystick_0  in  32  hps_io player 1 joystick; only bits [10:0] used
- joystick_1  in  32  hps_io player 2 joystick; only bits [10:0] used
- osd_open  in  1  high while the OSD has focus; clears and freezes keyboard state
- p1_ctrl  out  11  player 1 word: [0] right, [1] left, [2] down, [3] up, [7:4] buttons 4..1, [8] start, [9] coin, [10] pause
- p2_ctrl  out  11  player 2 word, same layout as p1_ctrl

Behaviour:
- Reset (async assert, sync release): all key registers, both ctrl outputs, coin counters, pause latches, and the primed flag go to 0.
- Event detect: toggle_q <= ps2_key[10] every cycle. An event occurs when primed=1 and ps2_key[10] != toggle_q.
  - primed is set on the first clock after reset release, so a stale toggle level at release is not decoded.
- Key map (ps2_key[8] ignored; right-hand ctrl/alt alias left-hand):
  - P1: 75 up, 72 down, 6B left, 74 right, 14 b1, 11 b2, 29 b3, 12 b4, 16 start, 2E coin, 4D pause.
  - P2: 2D up, 2B down, 23 left, 34 right, 1C b1, 1B b2, 15 b3, 1D b4, 1E start, 36 coin.
  - P2 has no keyboard pause.
  - On an event, the matching key register <= ps2_key[9]. Unmapped codes are ignored.
- osd_open=1: all key registers are cleared that cycle and events are ignored while high. If an event and osd_open=1 occur in the same cycle, the clear wins. Joystick paths are unaffected.
- raw[n] = key_state[n] | joystick[n] for n = 0..10 per player.
- Bits 8..0 of p*_ctrl are raw registered: 1 cycle latency from a joystick change, 2 cycles from a ps2_key toggle change.
- Coin (per player): FSM IDLE -> PULSE -> WAIT_RELEASE.
  - IDLE: on a raw coin rising edge, load the counter with COIN_CYCLES and go to PULSE; coin output = 1 from the next cycle.
  - PULSE: decrement each cycle; coin output deasserts after exactly COIN_CYCLES high cycles.
  - On counter reaching zero: if raw coin = 1, go to WAIT_RELEASE; else go to IDLE.
  - WAIT_RELEASE: output 0; return to IDLE when raw coin = 0.
  - A held or jammed coin therefore yields exactly one pulse. A raw release during PULSE does not shorten the pulse.
  - Counter width is $clog2(COIN_CYCLES+1).
- Pause: with PAUSE_TOGGLE=1, a rising edge of raw pause flips the latch and bit 10 = latch. With PAUSE_TOGGLE=0, bit 10 = registered raw pause.
- Joystick bits [31:11] are ignored.

Optional Feature:
- Macro: INPUT_SOCD_EN.
- Defined: after the OR stage, simultaneous up+down forces both to 0, and simultaneous left+right forces both to 0, per player, before the output register. No extra latency.
- Undefined: opposing directions pass through unmodified.

Test Plan:
- Reset release with ps2_key[10]=1 held static -> no key registered; p1_ctrl=0 for 100 cycles.
- ps2_key={toggle flip, pressed=1, code 75}, then release event (pressed=0) -> p1_ctrl[3]=1 two cycles after the first flip, =0 two cycles after the release flip. A second 75 press plus joystick_0[3]=1, then release 75 -> p1_ctrl[3] stays 1.
- COIN_CYCLES=8:
  - joystick_1[9] held high for 50 cycles -> p2_ctrl[9] high for exactly 8 cycles, once.
  - Release, then repress -> a second 8-cycle pulse.
  - 2-cycle raw tap -> still 8 cycles.
- PAUSE_TOGGLE=1: press/release key 4D twice -> p1_ctrl[10] goes 1 after the first press and 0 after the second.
- Key 14 held, then osd_open=1 for 1 cycle coincident with a key 16 press event -> p1_ctrl[4]=0, p1_ctrl[8]=0. joystick_0[5]=1 during osd_open -> p1_ctrl[5]=1.
- INPUT_SOCD_EN defined, joystick_0[1:0]=2'b11 -> p1_ctrl[1:0]=0. Undefined -> 2'b11.
